// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state encoding,
// control-bundle layout and the load opcode.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT = 2'd3;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctl_t;

  localparam ctl_t CTL_RUN    = 7'b1111100;
  localparam ctl_t CTL_RESET  = 7'b1111111;
  localparam ctl_t CTL_BRANCH = 7'b1111111;
  localparam ctl_t CTL_FREEZE = 7'b0000000;
  localparam ctl_t CTL_KILL   = 7'b1111110;
  localparam ctl_t CTL_LU     = 7'b0011101;

  function automatic logic is_load_opcode(input logic [6:0] opcode);
    return opcode == OPC_LOAD;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, register enables/flushes out.
// Counter outputs exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             br_infact_ex;
  logic             mem_req;
  logic             mem_ack;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       state_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
`endif

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread,
    output br_infact_ex, mem_req, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, state_o
`ifdef PIPE_HAZARD_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread,
    input  br_infact_ex, mem_req, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, state_o
`ifdef PIPE_HAZARD_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the EX load and the ID sources.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_uses_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_memread,
  output logic             o_lu_hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    w_rs1_hit   = (i_ex_rd == i_id_rs1);
    w_rs2_hit   = i_id_uses_rs2 && (i_ex_rd == i_id_rs2);
    o_lu_hazard = i_ex_memread && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard FSM: load-use stall, mispredict flush, data-memory freeze.
// Define PIPE_HAZARD_PERF_EN to add saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  logic [1:0] r_state;
  logic [1:0] w_next;
  ctl_t       w_ctl;
  logic       w_lu_hazard;
  logic       w_mem_stall;
  logic       w_br_take;

  hazard_detect u_hazard_detect (
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_uses_rs2 (bus.id_uses_rs2),
    .i_ex_rd       (bus.ex_rd),
    .i_ex_memread  (bus.ex_memread),
    .o_lu_hazard   (w_lu_hazard)
  );

  assign w_mem_stall = bus.mem_req && !bus.mem_ack;

  // MEM_WAIT is checked before the branch: EX is frozen, so the branch re-presents after the ack.
  always_comb begin
    w_ctl     = CTL_RUN;
    w_next    = ST_RUN;
    w_br_take = 1'b0;
    if (rst) begin
      w_ctl = CTL_RESET;
    end else if (r_state == ST_MEM_WAIT) begin
      if (!bus.mem_ack) begin
        w_ctl  = CTL_FREEZE;
        w_next = ST_MEM_WAIT;
      end
    end else if (bus.br_infact_ex) begin
      w_ctl     = CTL_BRANCH;
      w_next    = ST_FLUSH;
      w_br_take = 1'b1;
    end else if (w_mem_stall) begin
      w_ctl  = CTL_FREEZE;
      w_next = ST_MEM_WAIT;
    end else if (r_state == ST_FLUSH) begin
      w_ctl = CTL_KILL;
    end else if (r_state == ST_RUN && w_lu_hazard) begin
      w_ctl  = CTL_LU;
      w_next = ST_LU_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next;
  end

  assign bus.pc_en       = w_ctl.pc_en;
  assign bus.if_id_en    = w_ctl.if_id_en;
  assign bus.id_ex_en    = w_ctl.id_ex_en;
  assign bus.ex_mem_en   = w_ctl.ex_mem_en;
  assign bus.mem_wb_en   = w_ctl.mem_wb_en;
  assign bus.if_id_flush = w_ctl.if_id_flush;
  assign bus.id_ex_flush = w_ctl.id_ex_flush;
  assign bus.state_o     = r_state;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctl.pc_en && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_br_take && r_flush_cnt != '1)    r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// reset-during-wait sequence, then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [6:0] E_RUN  = 7'b1111100;
  localparam logic [6:0] E_ALL  = 7'b1111111;
  localparam logic [6:0] E_LU   = 7'b0011101;
  localparam logic [6:0] E_FRZ  = 7'b0000000;
  localparam logic [6:0] E_KILL = 7'b1111110;

  typedef struct {
    logic       br, mreq, mack, memrd;
    logic [4:0] exrd, rs1, rs2;
    logic       use2;
    logic [6:0] ctl;
    logic [1:0] st;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hif ();
  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(hif));

  int n_vec = 0;
  int n_err = 0;

  logic        m_wait, m_kill, m_bubble;
  logic [31:0] m_stall, m_flush;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en,
            hif.if_id_flush, hif.id_ex_flush};
  endfunction

  function automatic vec_t mk(input logic br, input logic mreq, input logic mack,
                              input logic memrd, input logic [4:0] exrd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic use2,
                              input logic [6:0] ctl, input logic [1:0] st);
    vec_t v;
    v.br = br; v.mreq = mreq; v.mack = mack; v.memrd = memrd;
    v.exrd = exrd; v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2;
    v.ctl = ctl; v.st = st;
    return v;
  endfunction

  task automatic drive(input logic br, input logic mreq, input logic mack, input logic memrd,
                       input logic [4:0] exrd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic use2);
    hif.br_infact_ex = br;
    hif.mem_req      = mreq;
    hif.mem_ack      = mack;
    hif.ex_memread   = memrd;
    hif.ex_rd        = exrd;
    hif.id_rs1       = rs1;
    hif.id_rs2       = rs2;
    hif.id_uses_rs2  = use2;
  endtask

  // Reference: three pending obligations (bubble given, wrong-path kill, memory wait)
  task automatic model_cycle(input int cyc);
    logic       hz;
    logic [6:0] e;
    logic [1:0] est;
    logic       n_wait, n_kill, n_bub, took_br;
    hz = hif.ex_memread && hif.ex_rd != 5'd0 &&
         (hif.ex_rd == hif.id_rs1 || (hif.id_uses_rs2 && hif.ex_rd == hif.id_rs2));
    est = m_wait ? 2'd3 : (m_kill ? 2'd2 : (m_bubble ? 2'd1 : 2'd0));
    n_wait = 1'b0; n_kill = 1'b0; n_bub = 1'b0; took_br = 1'b0;
    if (rst) e = E_ALL;
    else if (m_wait) begin
      e = hif.mem_ack ? E_RUN : E_FRZ;
      n_wait = !hif.mem_ack;
    end else if (hif.br_infact_ex) begin
      e = E_ALL; n_kill = 1'b1; took_br = 1'b1;
    end else if (hif.mem_req && !hif.mem_ack) begin
      e = E_FRZ; n_wait = 1'b1;
    end else if (m_kill) e = E_KILL;
    else if (!m_bubble && hz) begin
      e = E_LU; n_bub = 1'b1;
    end else e = E_RUN;
    chk($sformatf("rnd%0d_ctl", cyc), {25'd0, ctl_now()}, {25'd0, e});
    chk($sformatf("rnd%0d_state", cyc), {30'd0, hif.state_o}, {30'd0, est});
`ifdef PIPE_HAZARD_PERF_EN
    chk($sformatf("rnd%0d_stall_cnt", cyc), hif.stall_cnt, m_stall);
    chk($sformatf("rnd%0d_flush_cnt", cyc), hif.flush_cnt, m_flush);
`endif
    if (rst) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (e[6] == 1'b0) m_stall = m_stall + 1;
      if (took_br) m_flush = m_flush + 1;
    end
    m_wait = n_wait; m_kill = n_kill; m_bubble = n_bub;
  endtask

  initial begin
    tbl[0]  = mk(0,0,0, 0, 5'd0, 5'd0, 5'd0, 0, E_RUN,  2'd0);
    tbl[1]  = mk(0,0,0, 1, 5'd5, 5'd5, 5'd0, 0, E_LU,   2'd0);
    tbl[2]  = mk(0,0,0, 1, 5'd5, 5'd5, 5'd0, 0, E_RUN,  2'd1);
    tbl[3]  = mk(0,0,0, 1, 5'd0, 5'd0, 5'd0, 0, E_RUN,  2'd0);
    tbl[4]  = mk(0,0,0, 1, 5'd7, 5'd1, 5'd7, 0, E_RUN,  2'd0);
    tbl[5]  = mk(0,0,0, 1, 5'd7, 5'd1, 5'd7, 1, E_LU,   2'd0);
    tbl[6]  = mk(0,0,0, 0, 5'd0, 5'd0, 5'd0, 0, E_RUN,  2'd1);
    tbl[7]  = mk(1,0,0, 0, 5'd0, 5'd0, 5'd0, 0, E_ALL,  2'd0);
    tbl[8]  = mk(0,0,0, 0, 5'd0, 5'd0, 5'd0, 0, E_KILL, 2'd2);
    tbl[9]  = mk(0,0,0, 0, 5'd0, 5'd0, 5'd0, 0, E_RUN,  2'd0);
    tbl[10] = mk(0,1,0, 0, 5'd0, 5'd0, 5'd0, 0, E_FRZ,  2'd0);
    tbl[11] = mk(0,1,0, 0, 5'd0, 5'd0, 5'd0, 0, E_FRZ,  2'd3);
    tbl[12] = mk(0,1,0, 0, 5'd0, 5'd0, 5'd0, 0, E_FRZ,  2'd3);
    tbl[13] = mk(0,1,1, 0, 5'd0, 5'd0, 5'd0, 0, E_RUN,  2'd3);
    tbl[14] = mk(0,1,1, 0, 5'd0, 5'd0, 5'd0, 0, E_RUN,  2'd0);
    tbl[15] = mk(1,0,0, 1, 5'd9, 5'd9, 5'd0, 0, E_ALL,  2'd0);
    tbl[16] = mk(0,0,0, 1, 5'd9, 5'd9, 5'd0, 0, E_KILL, 2'd2);
    tbl[17] = mk(0,1,0, 0, 5'd0, 5'd0, 5'd0, 0, E_FRZ,  2'd0);
    tbl[18] = mk(1,1,0, 0, 5'd0, 5'd0, 5'd0, 0, E_FRZ,  2'd3);
    tbl[19] = mk(0,1,1, 0, 5'd0, 5'd0, 5'd0, 0, E_RUN,  2'd3);
    tbl[20] = mk(0,0,0, 0, 5'd0, 5'd0, 5'd0, 0, E_RUN,  2'd0);

    rst = 1'b1;
    drive(0,0,0,0,5'd0,5'd0,5'd0,0);
    @(negedge clk); #1;
    chk("reset_ctl", {25'd0, ctl_now()}, {25'd0, E_ALL});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", {30'd0, hif.state_o}, {30'd0, ST_RUN});
`ifdef PIPE_HAZARD_PERF_EN
    chk("reset_stall_cnt", hif.stall_cnt, 32'd0);
    chk("reset_flush_cnt", hif.flush_cnt, 32'd0);
`endif

    for (int unsigned i = 0; i < 21; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].br, tbl[i].mreq, tbl[i].mack, tbl[i].memrd,
            tbl[i].exrd, tbl[i].rs1, tbl[i].rs2, tbl[i].use2);
      #1;
      chk($sformatf("vec%0d_ctl", i), {25'd0, ctl_now()}, {25'd0, tbl[i].ctl});
      chk($sformatf("vec%0d_state", i), {30'd0, hif.state_o}, {30'd0, tbl[i].st});
    end
`ifdef PIPE_HAZARD_PERF_EN
    @(negedge clk);
    drive(0,0,0,0,5'd0,5'd0,5'd0,0);
    #1;
    chk("table_stall_cnt", hif.stall_cnt, 32'd7);
    chk("table_flush_cnt", hif.flush_cnt, 32'd2);
`endif

    // Reset while frozen in MEM_WAIT
    @(negedge clk);
    drive(0,1,0,0,5'd0,5'd0,5'd0,0);
    @(negedge clk); #1;
    chk("rstwait_pre_state", {30'd0, hif.state_o}, {30'd0, ST_MEM_WAIT});
    rst = 1'b1;
    #1;
    chk("rstwait_ctl", {25'd0, ctl_now()}, {25'd0, E_ALL});
    @(negedge clk);
    rst = 1'b0;
    drive(0,0,0,0,5'd0,5'd0,5'd0,0);
    #1;
    chk("rstwait_state", {30'd0, hif.state_o}, {30'd0, ST_RUN});
    chk("rstwait_run_ctl", {25'd0, ctl_now()}, {25'd0, E_RUN});
`ifdef PIPE_HAZARD_PERF_EN
    chk("rstwait_stall_cnt", hif.stall_cnt, 32'd0);
`endif

    m_wait = 1'b0; m_kill = 1'b0; m_bubble = 1'b0;
    m_stall = 0; m_flush = 0;
    for (int unsigned c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      #1;
      model_cycle(int'(c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset, with ports listed clock and reset first.
REQ-002 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 id_uses_rs2  in  1  ID instruction reads rs2.
REQ-006 ex_rd  in  5  destination register of the instruction in EX.
REQ-007 ex_memread  in  1  EX instruction is a load.
REQ-008 br_infact_ex  in  1  EX branch resolved as mispredicted; redirect to pred_pc_ex.
REQ-009 mem_req  in  1  MEM stage is issuing a data_mem access.
REQ-010 mem_ack  in  1  data_mem access complete.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables.
REQ-012 if_id_flush, id_ex_flush  out  1 each  insert bubble (NOP) into the register.
REQ-013 state_o  out  2  current FSM state, for debug.

Function
REQ-014 The FSM SHALL have the states RUN=0, LU_STALL=1, FLUSH=2 and MEM_WAIT=3.
REQ-015 A load-use hazard SHALL exist when ex_memread=1, ex_rd!=0, and ex_rd equals id_rs1 or (id_uses_rs2 and ex_rd equals id_rs2).
REQ-016 Event priority, highest first, SHALL be: rst, then br_infact_ex, then mem_req&!mem_ack, then load-use.
REQ-017 In RUN with no event, all enables SHALL be 1 and all flushes 0.
REQ-018 On load-use in RUN:
  - same cycle: pc_en=0, if_id_en=0, id_ex_flush=1;
  - next state: LU_STALL.
REQ-019 In LU_STALL, enables SHALL be 1 and flushes 0 for exactly 1 cycle, then the FSM SHALL return to RUN; the stall is therefore exactly 1 bubble.
REQ-020 On br_infact_ex in any state, the same cycle SHALL drive:
  - if_id_flush=1, id_ex_flush=1;
  - pc_en=1, so the redirect PC loads;
  - next state: FLUSH.
REQ-021 In FLUSH, if_id_flush SHALL be 1 for 1 further cycle, because the wrong-path fetch already in flight is killed; the FSM then SHALL go to RUN.
REQ-022 On mem_req=1 with mem_ack=0:
  - every enable SHALL be 0 and every flush 0 (the whole pipeline freezes);
  - next state: MEM_WAIT.
REQ-023 In MEM_WAIT the freeze SHALL hold until mem_ack=1; the cycle with mem_ack=1 SHALL assert all enables, and the next state SHALL be RUN.
REQ-024 mem_req and mem_ack both 1 in the same RUN cycle SHALL cause no stall.
REQ-025 br_infact_ex during MEM_WAIT SHALL be ignored, since the EX register is frozen and the branch re-presents after the ack.
REQ-026 A load-use hazard during MEM_WAIT or FLUSH SHALL be ignored in that cycle and evaluated again once the FSM is in RUN.
REQ-027 Outputs SHALL be combinational from state and inputs, and the latency from event to control SHALL be 0 cycles.

Reset
REQ-028 rst=1 SHALL force state=RUN; for that cycle it SHALL drive all enables to 1, if_id_flush=1 and id_ex_flush=1.
REQ-029 Reset mid-operation, in any state, SHALL take priority; the FSM SHALL resume in RUN on the cycle after rst deasserts.

Configuration
REQ-030 The macro PIPE_HAZARD_PERF_EN SHALL gate the performance counters.
REQ-031 With PIPE_HAZARD_PERF_EN defined, the block SHALL add these outputs:
  - stall_cnt (32): counts cycles with pc_en=0;
  - flush_cnt (32): counts br_infact_ex events.
REQ-032 The counters SHALL reset to 0 on rst and SHALL saturate at 32'hFFFFFFFF.
REQ-033 Without PIPE_HAZARD_PERF_EN, the counter ports and logic SHALL be absent and the behaviour otherwise identical.

Structure
REQ-034 A shared package SHALL hold the state encoding constants (RUN, LU_STALL, FLUSH, MEM_WAIT) and the opcode constant for loads (7'b0000011).
REQ-035 One sub-module, hazard_detect, SHALL hold the combinational load-use comparator; all remaining logic SHALL stay in pipe_hazard_ctrl.

Verification
REQ-036 Load-use:
  - stimulus: ex_memread=1, ex_rd=5, id_rs1=5;
  - response: pc_en=0 and id_ex_flush=1 for 1 cycle, state LU_STALL, then RUN with all enables 1.
REQ-037 x0 exclusion:
  - stimulus: ex_memread=1, ex_rd=0, id_rs1=0;
  - response: no stall, state stays RUN.
REQ-038 Mispredict:
  - stimulus: br_infact_ex=1 for 1 cycle;
  - response: if_id_flush=1 for 2 cycles and id_ex_flush=1 for 1 cycle, pc_en=1 throughout, state RUN again after 2 cycles.
REQ-039 Memory wait:
  - stimulus: mem_req=1, mem_ack=0 for 3 cycles, then mem_ack=1;
  - response: all enables 0 for 3 cycles, all 1 on the ack cycle, state MEM_WAIT then RUN.
REQ-040 Simultaneous events:
  - stimulus: br_infact_ex=1 together with a load-use hazard in RUN;
  - response: the flush behaviour of REQ-020 only, no LU_STALL entry.
REQ-041 Reset mid-stall:
  - stimulus: rst=1 while in MEM_WAIT;
  - response: next state RUN, and with PIPE_HAZARD_PERF_EN defined stall_cnt=0.
